// File: rtl/ahb_slave_mem.sv
// AHB-Lite memory slave: word-organised storage with byte/halfword/word
// access, a fixed number of wait states on every OKAY transfer, and a
// two-cycle ERROR response for out-of-range or misaligned requests.
module ahb_slave_mem #(
  parameter int MEM_WORDS   = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  // Word-index width and byte-address width of the storage.
  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int AW    = IDX_W + 2;

  // Wait counter reload: the WAIT state lasts WAIT_STATES cycles
  // (counts WAIT_STATES-1 down to 0 inclusive).
  localparam logic [3:0] LP_WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [3:0]         r_cnt;
  logic [3:0]         w_cnt_nxt;

  // Address-phase information held for the data phase.
  logic [31:0]        r_addr;
  logic               r_write;
  logic [2:0]         r_size;

  // Storage; deliberately left without reset.
  logic [31:0]        r_mem [MEM_WORDS];

  logic               w_boundary;
  logic               w_accept;
  logic               w_err;
  logic [IDX_W-1:0]   w_idx;
  logic [3:0]         w_lanes;
  logic               w_unused;

  // Request is illegal if it falls outside storage, is wider than a word,
  // or is not naturally aligned for its size.
  function automatic logic addr_err(input logic [31:0] addr, input logic [2:0] size);
    logic err;
    err = 1'b0;
    if (|addr[31:AW])                        err = 1'b1;
    if (size > 3'd2)                         err = 1'b1;
    if ((size == 3'd1) && addr[0])           err = 1'b1;
    if ((size == 3'd2) && (addr[1:0] != 2'b00)) err = 1'b1;
    return err;
  endfunction

  // Little-endian byte-lane enables for a legal (size, offset) pair.
  function automatic logic [3:0] byte_lanes(input logic [2:0] size, input logic [1:0] ofs);
    logic [3:0] lanes;
    case (size)
      3'd0:    lanes = 4'b0001 << ofs;
      3'd1:    lanes = ofs[1] ? 4'b1100 : 4'b0011;
      default: lanes = 4'b1111;
    endcase
    return lanes;
  endfunction

  // A new address phase can only be taken where the previous transfer ends
  // (or nothing is in flight), which gives back-to-back pipelining.
  assign w_boundary = (r_state == S_IDLE) || (r_state == S_DATA) || (r_state == S_ERR2);
  assign w_accept   = HSEL && HREADY && HTRANS[1] && w_boundary;
  assign w_err      = addr_err(HADDR, HSIZE);
  assign w_idx      = r_addr[AW-1:2];
  assign w_lanes    = byte_lanes(r_size, r_addr[1:0]);

  // Burst type, the SEQ/NONSEQ distinction and upper address bits carry no
  // information this slave needs.
  assign w_unused   = ^{HBURST, HTRANS[0], r_addr[31:AW]};

  // State register and wait counter.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_DATA;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_ERR1: begin
        // ERR2 always follows, whatever the bus does meanwhile.
        w_state_nxt = S_ERR2;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
        if (w_accept) begin
          if (w_err) begin
            w_state_nxt = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = LP_WS_LOAD;
          end else begin
            w_state_nxt = S_DATA;
          end
        end
      end
    endcase
  end

  // Response outputs decoded from the current state.
  always_comb begin
    HREADYOUT = !((r_state == S_WAIT) || (r_state == S_ERR1));
    HRESP     = (r_state == S_ERR1) || (r_state == S_ERR2);
    HRDATA    = 32'd0;
    if ((r_state == S_DATA) && !r_write) begin
      HRDATA = r_mem[w_idx];
    end
  end

  // Capture address-phase controls of an accepted transfer.
  always_ff @(posedge HCLK) begin
    if (w_accept) begin
      r_addr  <= HADDR;
      r_write <= HWRITE;
      r_size  <= HSIZE;
    end
  end

  // Commit write data at the end of the DATA cycle; reset suppresses it.
  always_ff @(posedge HCLK) begin
    if (HRESETn && (r_state == S_DATA) && r_write) begin
      for (int b = 0; b < 4; b++) begin
        if (w_lanes[b]) begin
          r_mem[w_idx][8*b +: 8] <= HWDATA[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: two instances (zero and two wait states) driven
// by a pipelined bus master and compared against a byte-level memory model.
module tb_ahb_slave_mem;

  typedef struct {
    bit        sel;
    bit [1:0]  trans;
    bit        wr;
    bit [31:0] addr;
    bit [2:0]  size;
    bit [31:0] wdata;
  } op_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        hsel      [2];
  logic [31:0] haddr     [2];
  logic [1:0]  htrans    [2];
  logic        hwrite    [2];
  logic [2:0]  hsize     [2];
  logic [2:0]  hburst    [2];
  logic [31:0] hwdata    [2];
  logic        hreadyout [2];
  logic        hresp     [2];
  logic [31:0] hrdata    [2];

  int          errors = 0;
  int          checks = 0;
  op_t         ops[$];
  bit [31:0]   model [2][64];
  logic [31:0] last_rd;

  always #5 clk = ~clk;

  ahb_slave_mem #(.MEM_WORDS(64), .WAIT_STATES(0)) u_dut0 (
    .HCLK(clk), .HRESETn(rstn), .HSEL(hsel[0]), .HADDR(haddr[0]),
    .HTRANS(htrans[0]), .HWRITE(hwrite[0]), .HSIZE(hsize[0]),
    .HBURST(hburst[0]), .HWDATA(hwdata[0]), .HREADY(hreadyout[0]),
    .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]), .HRDATA(hrdata[0])
  );

  ahb_slave_mem #(.MEM_WORDS(64), .WAIT_STATES(2)) u_dut1 (
    .HCLK(clk), .HRESETn(rstn), .HSEL(hsel[1]), .HADDR(haddr[1]),
    .HTRANS(htrans[1]), .HWRITE(hwrite[1]), .HSIZE(hsize[1]),
    .HBURST(hburst[1]), .HWDATA(hwdata[1]), .HREADY(hreadyout[1]),
    .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]), .HRDATA(hrdata[1])
  );

  function automatic op_t mk(bit sel, bit [1:0] trans, bit wr, bit [31:0] addr,
                             bit [2:0] size, bit [31:0] wdata);
    op_t o;
    o.sel = sel; o.trans = trans; o.wr = wr;
    o.addr = addr; o.size = size; o.wdata = wdata;
    return o;
  endfunction

  function automatic bit is_err(op_t o);
    return (o.addr >= 32'd256) || (o.size > 3'd2) ||
           ((o.size == 3'd1) && (o.addr % 2 != 0)) ||
           ((o.size == 3'd2) && (o.addr % 4 != 0));
  endfunction

  function automatic bit qualifies(op_t o);
    return o.sel && (o.trans == 2'b10 || o.trans == 2'b11);
  endfunction

  task automatic model_write(input int d, input op_t o);
    int nb;
    int w;
    int ln;
    nb = 1 << o.size;
    w  = o.addr / 4;
    for (int b = 0; b < nb; b++) begin
      ln = (o.addr % 4) + b;
      model[d][w][8*ln +: 8] = o.wdata[8*ln +: 8];
    end
  endtask

  task automatic idle_bus(input int d);
    hsel[d] = 1'b0; htrans[d] = 2'b00; hwrite[d] = 1'b0; haddr[d] = 32'd0;
    hsize[d] = 3'd0; hburst[d] = 3'd0; hwdata[d] = 32'd0;
  endtask

  task automatic drive_addr(input int d, input op_t o);
    hsel[d] = o.sel; htrans[d] = o.trans; hwrite[d] = o.wr;
    haddr[d] = o.addr; hsize[d] = o.size; hburst[d] = 3'($urandom);
  endtask

  // Plays the queued operations as a pipelined master and checks every cycle.
  task automatic run_ops(input int d, input string name);
    int   ws;
    bit   act;
    int   pos;
    int   idx;
    int   guard;
    bit   done;
    bit   exp_rdy;
    bit   exp_resp;
    logic [31:0] exp_rd;
    op_t  cur;
    op_t  nxt;
    ws = (d == 0) ? 0 : 2;
    act = 1'b0; pos = 0; idx = 0; guard = 0;
    cur = mk(0, 0, 0, 0, 0, 0);
    while ((idx < ops.size() || act) && guard < 20000) begin
      guard++;
      nxt = mk(0, 0, 0, 0, 0, 0);
      exp_rdy = 1'b1; exp_resp = 1'b0; exp_rd = 32'd0; done = 1'b1;
      if (act) begin
        if (is_err(cur)) begin
          exp_resp = 1'b1;
          exp_rdy  = (pos == 1);
          done     = (pos == 1);
        end else begin
          exp_rdy = (pos == ws);
          done    = (pos == ws);
          if (done && !cur.wr) exp_rd = model[d][cur.addr / 4];
        end
      end
      checks++;
      if (hreadyout[d] !== exp_rdy || hresp[d] !== exp_resp || hrdata[d] !== exp_rd) begin
        errors++;
        $display("FAIL %s dut%0d op%0d pos%0d: got rdy=%b resp=%b rdata=%h, want rdy=%b resp=%b rdata=%h",
                 name, d, idx, pos, hreadyout[d], hresp[d], hrdata[d], exp_rdy, exp_resp, exp_rd);
      end
      if (act && done && !is_err(cur) && !cur.wr) last_rd = hrdata[d];
      hwdata[d] = (act && cur.wr) ? cur.wdata : $urandom;
      if (act && done && !is_err(cur) && cur.wr) model_write(d, cur);
      if (done) begin
        if (idx < ops.size()) begin
          nxt = ops[idx];
          idx++;
          drive_addr(d, nxt);
        end else begin
          hsel[d] = 1'b0; htrans[d] = 2'b00;
        end
      end else begin
        // Bus is stalled: the slave must ignore whatever is on it.
        hsel[d] = 1'($urandom); htrans[d] = 2'($urandom); haddr[d] = $urandom;
        hwrite[d] = 1'($urandom); hsize[d] = 3'($urandom);
      end
      @(posedge clk); #1;
      if (done) begin
        act = qualifies(nxt);
        cur = nxt;
        pos = 0;
      end else begin
        pos++;
      end
    end
    if (guard >= 20000) begin
      errors++;
      checks++;
      $display("FAIL %s dut%0d timeout: got %0d cycles, want under 20000", name, d, guard);
    end
    ops.delete();
    idle_bus(d);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle_bus(0); idle_bus(1);
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (hreadyout[d] !== 1'b1 || hresp[d] !== 1'b0 || hrdata[d] !== 32'd0) begin
        errors++;
        $display("FAIL reset dut%0d: got rdy=%b resp=%b rdata=%h, want rdy=1 resp=0 rdata=00000000",
                 d, hreadyout[d], hresp[d], hrdata[d]);
      end
    end
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_init(input int d);
    for (int w = 0; w < 64; w++) ops.push_back(mk(1, 2'b10, 1, 32'(w * 4), 3'd2, $urandom));
    run_ops(d, "init");
  endtask

  task automatic test_write_read(input int d);
    last_rd = 32'd0;
    ops.push_back(mk(1, 2'b10, 1, 32'h10, 3'd2, 32'hDEADBEEF));
    ops.push_back(mk(1, 2'b10, 0, 32'h04, 3'd2, 32'd0));
    ops.push_back(mk(1, 2'b10, 0, 32'h10, 3'd2, 32'd0));
    run_ops(d, "write_read");
    checks++;
    if (last_rd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL write_read dut%0d: got %h, want deadbeef", d, last_rd);
    end
  endtask

  task automatic test_byte_lanes(input int d);
    last_rd = 32'd0;
    ops.push_back(mk(1, 2'b10, 1, 32'h10, 3'd2, 32'h11223344));
    ops.push_back(mk(1, 2'b10, 1, 32'h13, 3'd0, 32'hAB000000));
    ops.push_back(mk(1, 2'b10, 0, 32'h10, 3'd2, 32'd0));
    run_ops(d, "byte_lanes");
    checks++;
    if (last_rd !== 32'hAB223344) begin
      errors++;
      $display("FAIL byte_lanes dut%0d: got %h, want ab223344", d, last_rd);
    end
  endtask

  task automatic test_error(input int d);
    last_rd = 32'd0;
    ops.push_back(mk(1, 2'b10, 0, 32'h100, 3'd2, 32'd0));
    ops.push_back(mk(1, 2'b10, 1, 32'h100, 3'd2, 32'h55AA55AA));
    ops.push_back(mk(1, 2'b10, 1, 32'h12, 3'd2, 32'h0));
    ops.push_back(mk(1, 2'b10, 1, 32'h11, 3'd1, 32'h0));
    ops.push_back(mk(1, 2'b10, 1, 32'h10, 3'd3, 32'h0));
    ops.push_back(mk(1, 2'b10, 0, 32'h00, 3'd2, 32'd0));
    ops.push_back(mk(1, 2'b10, 0, 32'h10, 3'd2, 32'd0));
    run_ops(d, "error");
    checks++;
    if (last_rd !== 32'hAB223344) begin
      errors++;
      $display("FAIL error_unchanged dut%0d: got %h, want ab223344", d, last_rd);
    end
  endtask

  task automatic test_burst_busy(input int d);
    last_rd = 32'd0;
    ops.push_back(mk(1, 2'b10, 1, 32'h20, 3'd2, 32'hA0A0A0A0));
    ops.push_back(mk(1, 2'b11, 1, 32'h24, 3'd2, 32'hB1B1B1B1));
    ops.push_back(mk(1, 2'b01, 1, 32'h28, 3'd2, 32'hFFFFFFFF));
    ops.push_back(mk(1, 2'b11, 1, 32'h28, 3'd2, 32'hC2C2C2C2));
    ops.push_back(mk(1, 2'b11, 1, 32'h2C, 3'd2, 32'hD3D3D3D3));
    for (int i = 0; i < 4; i++) ops.push_back(mk(1, 2'b10, 0, 32'(32'h20 + 4 * i), 3'd2, 32'd0));
    run_ops(d, "burst_busy");
    checks++;
    if (last_rd !== 32'hD3D3D3D3) begin
      errors++;
      $display("FAIL burst_last dut%0d: got %h, want d3d3d3d3", d, last_rd);
    end
  endtask

  task automatic test_reset_abort(input int d);
    bit [31:0] old;
    old = model[d][12];
    drive_addr(d, mk(1, 2'b10, 1, 32'h30, 3'd2, 32'd0));
    @(posedge clk); #1;
    checks++;
    if (hreadyout[d] !== ((d == 0) ? 1'b1 : 1'b0) || hresp[d] !== 1'b0) begin
      errors++;
      $display("FAIL abort_phase dut%0d: got rdy=%b resp=%b, want rdy=%b resp=0",
               d, hreadyout[d], hresp[d], (d == 0) ? 1'b1 : 1'b0);
    end
    hwdata[d] = ~old;
    hsel[d] = 1'b0; htrans[d] = 2'b00;
    rstn = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (hreadyout[d] !== 1'b1 || hresp[d] !== 1'b0 || hrdata[d] !== 32'd0) begin
      errors++;
      $display("FAIL abort_reset dut%0d: got rdy=%b resp=%b rdata=%h, want rdy=1 resp=0 rdata=00000000",
               d, hreadyout[d], hresp[d], hrdata[d]);
    end
    rstn = 1'b1;
    last_rd = 32'd0;
    ops.push_back(mk(1, 2'b10, 0, 32'h30, 3'd2, 32'd0));
    run_ops(d, "abort_read");
    checks++;
    if (last_rd !== old) begin
      errors++;
      $display("FAIL abort_unchanged dut%0d: got %h, want %h", d, last_rd, old);
    end
  endtask

  task automatic test_random(input int d);
    bit [31:0] prev;
    prev = 32'd0;
    for (int i = 0; i < 150; i++) begin
      op_t o;
      o.sel = ($urandom_range(0, 9) != 0);
      case ($urandom_range(0, 9))
        0:          o.trans = 2'b00;
        1:          o.trans = 2'b01;
        2, 3, 4, 5: o.trans = 2'b10;
        default:    o.trans = 2'b11;
      endcase
      o.wr   = 1'($urandom_range(0, 1));
      o.size = ($urandom_range(0, 11) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0)       o.addr = prev;
      else if ($urandom_range(0, 11) == 0) o.addr = $urandom_range(256, 1023);
      else                                 o.addr = $urandom_range(0, 255);
      if ($urandom_range(0, 4) != 0 && o.size <= 3'd2)
        o.addr = o.addr & ~((32'd1 << o.size) - 32'd1);
      o.wdata = $urandom;
      prev = o.addr;
      ops.push_back(o);
    end
    run_ops(d, "random");
  endtask

  initial begin
    last_rd = 32'd0;
    test_reset();
    for (int d = 0; d < 2; d++) begin
      test_init(d);
      test_write_read(d);
      test_byte_lanes(d);
      test_error(d);
      test_burst_busy(d);
      test_reset_abort(d);
      test_random(d);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
